// File: rtl/store_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_ctrl_if
// Bundles the signals between the store-path controller, the execute stage,
// the trap logic and the data-memory write port.
//
// Signals
//   st_valid/st_ready     : store handshake from execute
//   st_type/addr/data     : store type (00 sw, 01 sh, 10 sb, 11 illegal),
//                           byte address, right-justified data
//   misalign/misalign_addr: rejected-store pulse and captured address
//   mem_req/mem_ack       : one-at-a-time write handshake to memory
//   mem_addr/wdata/be     : word address, lane-replicated data, byte enables
//   busy                  : store buffer non-empty
//
// Modports
//   slave  : the store controller itself
//   master : the surrounding environment (execute, memory, trap logic)
// ---------------------------------------------------------------------------
interface store_ctrl_if;

    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        busy;

    modport slave (
        input  st_valid, st_type, st_addr, st_data, mem_ack,
        output st_ready, misalign, misalign_addr,
               mem_req, mem_addr, mem_wdata, mem_be, busy
    );

    modport master (
        output st_valid, st_type, st_addr, st_data, mem_ack,
        input  st_ready, misalign, misalign_addr,
               mem_req, mem_addr, mem_wdata, mem_be, busy
    );

endinterface

// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
// Store-path controller between execute and the data-memory write port.
// Each store accepted on the st_valid/st_ready handshake is alignment
// checked; legal stores are formatted (word address, replicated data, byte
// enables) and pushed into an in-order buffer of DEPTH entries, illegal or
// misaligned ones are reported to the trap logic instead. The buffer head is
// drained to memory over mem_req/mem_ack, one store at a time.
//
// Parameters
//   DEPTH : store-buffer entries, power of two, >= 2
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   bus   : store_ctrl_if.slave, see the interface file for signal meanings
// ---------------------------------------------------------------------------
module store_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    store_ctrl_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Buffer storage; entries are only ever observed through the head pointer
    // while in REQ, so they need no reset.
    logic [31:0]   r_fifoAddr [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [3:0]    r_fifoBe   [DEPTH];

    logic [PW-1:0] r_headPtr;
    logic [PW-1:0] r_tailPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countNext;

    state_t        r_state;
    state_t        w_stateNext;

    logic          r_misalign;
    logic [31:0]   r_misalignAddr;

    logic          w_ready;
    logic          w_accept;
    logic          w_illegal;
    logic          w_push;
    logic          w_reject;
    logic          w_pop;

    logic [31:0]   w_fmtAddr;
    logic [31:0]   w_fmtData;
    logic [3:0]    w_fmtBe;

    logic          w_memReq;
    logic [31:0]   w_memAddr;
    logic [31:0]   w_memWdata;
    logic [3:0]    w_memBe;

    // st_ready only looks at the registered count, so an ack popping a full
    // buffer does not make room until the following cycle.
    assign w_ready  = (r_count != CW'(DEPTH));
    assign w_accept = bus.st_valid && w_ready;
    assign w_push   = w_accept && !w_illegal;
    assign w_reject = w_accept && w_illegal;
    assign w_pop    = (r_state == REQ) && bus.mem_ack;

    assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

    // Alignment check and write formatting of the incoming store.
    always_comb begin
        w_illegal = 1'b0;
        w_fmtAddr = {bus.st_addr[31:2], 2'b00};
        w_fmtData = 32'h0;
        w_fmtBe   = 4'b0000;
        case (bus.st_type)
            2'b00: begin
                w_illegal = (bus.st_addr[1:0] != 2'b00);
                w_fmtBe   = 4'b1111;
                w_fmtData = bus.st_data;
            end
            2'b01: begin
                w_illegal = bus.st_addr[0];
                w_fmtBe   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                w_fmtData = {bus.st_data[15:0], bus.st_data[15:0]};
            end
            2'b10: begin
                w_fmtBe   = 4'b0001 << bus.st_addr[1:0];
                w_fmtData = {4{bus.st_data[7:0]}};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Entry write at the tail.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifoAddr[r_tailPtr] <= w_fmtAddr;
            r_fifoData[r_tailPtr] <= w_fmtData;
            r_fifoBe[r_tailPtr]   <= w_fmtBe;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tailPtr <= r_tailPtr + PW'(1);
            end
            if (w_pop) begin
                r_headPtr <= r_headPtr + PW'(1);
            end
            r_count <= w_countNext;
        end
    end

    // Rejection report: one-cycle pulse, address held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign     <= 1'b0;
            r_misalignAddr <= 32'h0;
        end else begin
            r_misalign <= w_reject;
            if (w_reject) begin
                r_misalignAddr <= bus.st_addr;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic is driven by the post-edge count so a push that
    // coincides with the last pop keeps the request up without a gap.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_countNext != '0) begin
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack && (w_countNext == '0)) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Memory-side outputs come from the head entry while requesting and are
    // held at zero otherwise.
    always_comb begin
        w_memReq   = 1'b0;
        w_memAddr  = 32'h0;
        w_memWdata = 32'h0;
        w_memBe    = 4'b0000;
        if (r_state == REQ) begin
            w_memReq   = 1'b1;
            w_memAddr  = r_fifoAddr[r_headPtr];
            w_memWdata = r_fifoData[r_headPtr];
            w_memBe    = r_fifoBe[r_headPtr];
        end
    end

    assign bus.st_ready      = w_ready;
    assign bus.misalign      = r_misalign;
    assign bus.misalign_addr = r_misalignAddr;
    assign bus.mem_req       = w_memReq;
    assign bus.mem_addr      = w_memAddr;
    assign bus.mem_wdata     = w_memWdata;
    assign bus.mem_be        = w_memBe;
    assign bus.busy          = (r_count != '0);

endmodule
